muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit that owns the HI/LO architectural registers. It succeeds the single-cycle multiply block in the pipelined datapath. The EX stage issues MULT/MULTU/DIV/DIVU/MTHI/MTLO. The unit computes one bit per cycle and exposes busy/stall so the hazard unit can hold MFHI/MFLO and any new muldiv issue until results are committed.

Parameters:
WIDTH, 32, operand width; HI and LO are WIDTH bits each (≥4, even).
CNT_W, $clog2(WIDTH), iteration counter width (derived).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  issue request from EX, sampled on clk
op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO, others=NOP
a  in  WIDTH  rs operand (multiplicand / dividend / MT data)
b  in  WIDTH  rt operand (multiplier / divisor)
flush  in  1  abort current operation (branch/exception squash)
rd_hilo  in  1  decode stage holds MFHI/MFLO
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
busy  out  1  operation in flight
done  out  1  one-cycle pulse when HI/LO committed by an op
stall  out  1  busy & (rd_hilo | start), to hazard unit
div_zero  out  1  sticky; set by DIV/DIVU with b==0, cleared by next accepted start

Behaviour:
- Reset (rst=0, async): state IDLE; hi=lo=0; busy=done=div_zero=0; counter, accumulators 0. Applies mid-operation; partial result is discarded.
- FSM: IDLE -> ITER -> FIX -> IDLE.
- IDLE: start & !flush with op 0-3 -> latch magnitudes |a|, |b| (signed ops) or raw (unsigned), result signs, counter=0; go ITER; busy=1 from next cycle.
- IDLE: op 4/5 -> write hi/lo=a at this edge; no busy, no done.
- IDLE: op 6/7 -> ignored.
- start while busy: ignored. The hazard unit guarantees it does not happen; stall covers it.
- ITER, multiply: 2*WIDTH-bit accumulator plus left-shifting 2*WIDTH-bit multiplicand; multiplier shifts right one bit per cycle; add when LSB=1.
- ITER, divide: restoring division, one quotient bit per cycle, WIDTH-bit remainder plus 1 guard bit.
- ITER leaves after WIDTH cycles (counter==WIDTH-1).
- FIX (1 cycle): apply sign correction and commit.
  - Multiply: {hi,lo}=product.
  - Divide: lo=quotient, hi=remainder; remainder takes the dividend's sign.
  - done=1 for the cycle after the FIX edge; busy=0 the same cycle.
- Latency: busy high for WIDTH+1 cycles; new results are readable when busy falls.
- Divide by zero (b==0): skip ITER, go directly to FIX; hi=a, lo=all ones, div_zero=1.
- Signed MIN/-1: lo=MIN (wraps), hi=0; no flag.
- flush: priority over start. While busy -> state IDLE next edge; hi/lo unchanged; no done. A start in the same cycle is ignored.
- hi/lo hold their old values for the whole operation; they change only at FIX, MT writes, or reset.

Optional Feature:
MULDIV_EARLY_OUT_EN.
- Defined: multiply ITER exits early once the remaining multiplier after the current shift is zero, with a minimum of 1 iteration. The result is identical because the multiplicand is pre-shifted.
- Undefined: every multiply takes WIDTH iterations. Divide is unaffected either way.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings (OP_MULT..OP_MTLO)
  - FSM state enum (S_IDLE, S_ITER, S_FIX)
  - result-sign helper constants
- One sub-module, muldiv_iter_core: the per-cycle add/subtract-shift datapath (accumulator, shifted operand, counter). muldiv_unit keeps the FSM, sign handling, HI/LO registers and hazard outputs.

Test Plan:
1. MULT a=0xFFFFFFFD (-3), b=7 -> busy 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB, done pulse 1 cycle.
2. MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MTHI a=0x12345678 idle -> hi=0x12345678 next cycle, busy stays 0.
3. DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=0 -> busy 1 cycle, hi=7, lo=0xFFFFFFFF, div_zero=1.
4. DIVU 100/7, flush on 10th ITER cycle with start=1 -> busy 0 next cycle, hi/lo unchanged, no done, start ignored. rd_hilo=1 while busy -> stall=1.
5. rst pulled low mid-MULT (cycle 15) -> busy, done, hi, lo all 0 immediately without a clock edge; after release, unit is idle.
6. MULTU 5*3: with MULDIV_EARLY_OUT_EN -> busy 3 cycles, lo=15; without the macro -> busy 33 cycles, lo=15, hi=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states
// and result-sign helpers.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  localparam logic SIGN_POS = 1'b0;
  localparam logic SIGN_NEG = 1'b1;

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_arith(input logic [2:0] op);
    return op <= OP_DIVU;
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One-bit-per-cycle datapath: shift-add multiply and restoring divide on unsigned
// magnitudes. Sign handling and sequencing live in muldiv_unit.
module muldiv_iter_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic                 is_div,
  input  logic [WIDTH-1:0]     opa,
  input  logic [WIDTH-1:0]     opb,
  output logic [2*WIDTH-1:0]   acc,
  output logic [WIDTH-1:0]     quo,
  output logic                 last,
  output logic                 rest_zero
);

  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   shreg_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               is_div_r;

  logic [2*WIDTH-1:0] sum_s;
  logic [WIDTH:0]     rem_sh_s;
  logic [WIDTH:0]     diff_s;

  // Candidate next values for both algorithms; divisor sits in mcand_r low half.
  always_comb begin
    sum_s    = acc_r + mcand_r;
    rem_sh_s = {acc_r[WIDTH-1:0], shreg_r[WIDTH-1]};
    diff_s   = rem_sh_s - {1'b0, mcand_r[WIDTH-1:0]};
  end

  // Operand load and per-cycle shift/add or shift/subtract.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r    <= '0;
      mcand_r  <= '0;
      shreg_r  <= '0;
      cnt_r    <= '0;
      is_div_r <= 1'b0;
    end else if (load) begin
      acc_r    <= '0;
      mcand_r  <= {{WIDTH{1'b0}}, (is_div ? opb : opa)};
      shreg_r  <= is_div ? opa : opb;
      cnt_r    <= '0;
      is_div_r <= is_div;
    end else if (step) begin
      cnt_r <= cnt_r + CNT_W'(1);
      if (is_div_r) begin
        // Remainder never exceeds WIDTH bits, so the guard bit only flags borrow.
        if (!diff_s[WIDTH]) begin
          acc_r   <= {{(WIDTH-1){1'b0}}, diff_s};
          shreg_r <= {shreg_r[WIDTH-2:0], 1'b1};
        end else begin
          acc_r   <= {{(WIDTH-1){1'b0}}, rem_sh_s};
          shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
        end
      end else begin
        if (shreg_r[0]) begin
          acc_r <= sum_s;
        end
        mcand_r <= {mcand_r[2*WIDTH-2:0], 1'b0};
        shreg_r <= {1'b0, shreg_r[WIDTH-1:1]};
      end
    end
  end

  assign acc       = acc_r;
  assign quo       = shreg_r;
  assign last      = (cnt_r == CNT_W'(WIDTH-1));
  assign rest_zero = (shreg_r[WIDTH-1:1] == '0);

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, with busy/stall for the hazard unit.
// Optional macro MULDIV_EARLY_OUT_EN lets multiplies stop once the multiplier is exhausted.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             rd_hilo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic             div_zero
);

`ifdef MULDIV_EARLY_OUT_EN
  localparam logic EARLY_OUT_EN = 1'b1;
`else
  localparam logic EARLY_OUT_EN = 1'b0;
`endif

  state_e state_r, state_n;

  logic [WIDTH-1:0] hi_r, lo_r;
  logic             busy_r, done_r, div_zero_r;
  logic             is_div_r, div0_pend_r, prod_neg_r, rem_neg_r;

  logic             accept_s, arith_s, div_op_s, sgn_s, b_zero_s, early_s;
  logic [WIDTH-1:0] a_mag_s, b_mag_s;
  logic [WIDTH-1:0] hi_fix_s, lo_fix_s;

  logic [2*WIDTH-1:0] core_acc_s;
  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0]   core_quo_s;
  logic               core_last_s, core_rest_zero_s;

  function automatic logic [WIDTH-1:0] cond_neg(input logic neg, input logic [WIDTH-1:0] v);
    return (neg == SIGN_NEG) ? -v : v;
  endfunction

  // Issue decode and operand magnitudes.
  always_comb begin
    accept_s = start & ~flush & (state_r == S_IDLE);
    arith_s  = accept_s & op_is_arith(op);
    div_op_s = op_is_div(op);
    sgn_s    = op_is_signed(op);
    b_zero_s = (b == '0);
    a_mag_s  = cond_neg(sgn_s & a[WIDTH-1], a);
    b_mag_s  = cond_neg(sgn_s & b[WIDTH-1], b);
    early_s  = EARLY_OUT_EN & ~is_div_r & core_rest_zero_s;
  end

  muldiv_iter_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (arith_s),
    .step      (state_r == S_ITER),
    .is_div    (div_op_s),
    .opa       (a_mag_s),
    .opb       (b_mag_s),
    .acc       (core_acc_s),
    .quo       (core_quo_s),
    .last      (core_last_s),
    .rest_zero (core_rest_zero_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic; flush abandons any operation in flight.
  always_comb begin
    state_n = state_r;
    case (state_r)
      S_IDLE: begin
        if (arith_s) begin
          state_n = (div_op_s && b_zero_s) ? S_FIX : S_ITER;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_ITER: begin
        if (flush) begin
          state_n = S_IDLE;
        end else if (core_last_s || early_s) begin
          state_n = S_FIX;
        end else begin
          state_n = S_ITER;
        end
      end
      S_FIX:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Sign-corrected commit values; divide-by-zero restores the dividend into HI.
  always_comb begin
    prod_fix_s = (prod_neg_r == SIGN_NEG) ? -core_acc_s : core_acc_s;
    if (div0_pend_r) begin
      hi_fix_s = cond_neg(rem_neg_r, core_quo_s);
      lo_fix_s = '1;
    end else if (is_div_r) begin
      hi_fix_s = cond_neg(rem_neg_r, core_acc_s[WIDTH-1:0]);
      lo_fix_s = cond_neg(prod_neg_r, core_quo_s);
    end else begin
      hi_fix_s = prod_fix_s[2*WIDTH-1:WIDTH];
      lo_fix_s = prod_fix_s[WIDTH-1:0];
    end
  end

  // Architectural HI/LO, status flags and latched operation attributes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_r        <= '0;
      lo_r        <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      div_zero_r  <= 1'b0;
      is_div_r    <= 1'b0;
      div0_pend_r <= 1'b0;
      prod_neg_r  <= SIGN_POS;
      rem_neg_r   <= SIGN_POS;
    end else begin
      done_r <= 1'b0;
      busy_r <= (state_n != S_IDLE);
      if (state_r == S_IDLE) begin
        if (arith_s) begin
          is_div_r    <= div_op_s;
          div0_pend_r <= div_op_s & b_zero_s;
          prod_neg_r  <= sgn_s & (a[WIDTH-1] ^ b[WIDTH-1]);
          rem_neg_r   <= sgn_s & a[WIDTH-1];
          div_zero_r  <= 1'b0;
        end else if (accept_s && (op == OP_MTHI)) begin
          hi_r       <= a;
          div_zero_r <= 1'b0;
        end else if (accept_s && (op == OP_MTLO)) begin
          lo_r       <= a;
          div_zero_r <= 1'b0;
        end
      end else if ((state_r == S_FIX) && !flush) begin
        hi_r   <= hi_fix_s;
        lo_r   <= lo_fix_s;
        done_r <= 1'b1;
        if (div0_pend_r) begin
          div_zero_r <= 1'b1;
        end
      end
    end
  end

  assign hi       = hi_r;
  assign lo       = lo_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign div_zero = div_zero_r;
  assign stall    = busy_r & (rd_hilo | start);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a cycle-level reference model is checked every
// cycle, and literal expectations pin the model on the key scenarios.
module tb_muldiv_unit;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        flush = 1'b0;
  logic        rd_hilo = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, done, stall, div_zero;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .rd_hilo(rd_hilo), .hi(hi), .lo(lo), .busy(busy),
    .done(done), .stall(stall), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Architectural result of an arithmetic op: {div_zero, hi, lo}.
  function automatic logic [64:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    int sx, sy;
    sx = $signed(x);
    sy = $signed(y);
    case (o)
      3'd0: begin p = longint'(sx) * longint'(sy); return {1'b0, p}; end
      3'd1: begin p = {32'd0, x} * {32'd0, y}; return {1'b0, p}; end
      3'd2: begin
        if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
        return {1'b0, 32'(sx % sy), 32'(sx / sy)};
      end
      3'd3: begin
        if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
        return {1'b0, x % y, x / y};
      end
      default: return 65'd0;
    endcase
  endfunction

  // Cycles busy stays high after issue.
  function automatic int ref_latency(input logic [2:0] o, input logic [31:0] y);
    int n;
    if (o >= 3'd2) return (y == 32'd0) ? 1 : 33;
    if (!EARLY) return 33;
    n = 1;
    for (int i = 1; i < 32; i++) if (y[i]) n = i + 1;
    return n + 1;
  endfunction

  int          m_left;
  logic [31:0] m_hi, m_lo, r_hi, r_lo;
  logic        m_done, m_dz, r_dz;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_left <= 0; m_hi <= 32'd0; m_lo <= 32'd0; m_done <= 1'b0; m_dz <= 1'b0;
      r_hi <= 32'd0; r_lo <= 32'd0; r_dz <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        if (flush) m_left <= 0;
        else begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_hi <= r_hi; m_lo <= r_lo; m_done <= 1'b1;
            if (r_dz) m_dz <= 1'b1;
          end
        end
      end else if (start && !flush) begin
        case (op)
          3'd0, 3'd1, 3'd2, 3'd3: begin
            {r_dz, r_hi, r_lo} <= ref_result(op, a, b);
            m_left <= ref_latency(op, b);
            m_dz <= 1'b0;
          end
          3'd4: begin m_hi <= a; m_dz <= 1'b0; end
          3'd5: begin m_lo <= a; m_dz <= 1'b0; end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("hi", {32'd0, hi}, {32'd0, m_hi});
      chk("lo", {32'd0, lo}, {32'd0, m_lo});
      chk("busy", {63'd0, busy}, {63'd0, m_left > 0});
      chk("done", {63'd0, done}, {63'd0, m_done});
      chk("div_zero", {63'd0, div_zero}, {63'd0, m_dz});
      chk("stall", {63'd0, stall}, {63'd0, (m_left > 0) && (rd_hilo || start)});
    end
  end

  // Called at posedge+1; returns at posedge+1 of the first non-busy cycle.
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, output int n);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    if (n >= 200) begin
      n_chk++; n_fail++;
      $display("FAIL op_timeout: busy still high after %0d cycles", n);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_lo", {32'd0, lo}, 64'd0);
    chk("idle_done", {63'd0, done}, 64'd0);
    chk("idle_dz", {63'd0, div_zero}, 64'd0);

    do_op(3'd0, 32'hFFFF_FFFD, 32'd7, cyc);
    chk("mult_cycles", 64'(cyc), EARLY ? 64'd4 : 64'd33);
    chk("mult_hi", {32'd0, hi}, 64'hFFFF_FFFF);
    chk("mult_lo", {32'd0, lo}, 64'hFFFF_FFEB);
    chk("mult_done", {63'd0, done}, 64'd1);
    @(posedge clk); #1;
    chk("mult_done_pulse", {63'd0, done}, 64'd0);

    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
    chk("multu_hi", {32'd0, hi}, 64'hFFFF_FFFE);
    chk("multu_lo", {32'd0, lo}, 64'h0000_0001);

    do_op(3'd4, 32'h1234_5678, 32'd0, cyc);
    chk("mthi_hi", {32'd0, hi}, 64'h1234_5678);
    chk("mthi_busy_cycles", 64'(cyc), 64'd0);
    chk("mthi_done", {63'd0, done}, 64'd0);
    do_op(3'd5, 32'hCAFE_0001, 32'd0, cyc);
    chk("mtlo_lo", {32'd0, lo}, 64'hCAFE_0001);
    do_op(3'd6, 32'h5555_5555, 32'd3, cyc);
    chk("nop_busy_cycles", 64'(cyc), 64'd0);
    chk("nop_hi_kept", {32'd0, hi}, 64'h1234_5678);

    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, cyc);
    chk("div_lo", {32'd0, lo}, 64'hFFFF_FFFD);
    chk("div_hi", {32'd0, hi}, 64'hFFFF_FFFF);
    chk("div_cycles", 64'(cyc), 64'd33);

    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    chk("min_div_lo", {32'd0, lo}, 64'h8000_0000);
    chk("min_div_hi", {32'd0, hi}, 64'd0);
    chk("min_div_dz", {63'd0, div_zero}, 64'd0);

    do_op(3'd3, 32'd7, 32'd0, cyc);
    chk("div0_cycles", 64'(cyc), 64'd1);
    chk("div0_hi", {32'd0, hi}, 64'd7);
    chk("div0_lo", {32'd0, lo}, 64'hFFFF_FFFF);
    chk("div0_flag", {63'd0, div_zero}, 64'd1);

    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; rd_hilo = 1'b1;
    chk("flush_busy", {63'd0, busy}, 64'd1);
    chk("flush_stall", {63'd0, stall}, 64'd1);
    repeat (9) @(posedge clk);
    #1;
    rd_hilo = 1'b0; flush = 1'b1; start = 1'b1; op = 3'd1; a = 32'd5; b = 32'd5;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    chk("flush_idle", {63'd0, busy}, 64'd0);
    chk("flush_no_done", {63'd0, done}, 64'd0);
    chk("flush_hi", {32'd0, hi}, 64'd7);
    chk("flush_lo", {32'd0, lo}, 64'hFFFF_FFFF);
    chk("flush_dz_cleared", {63'd0, div_zero}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("flush_start_ignored", {63'd0, busy}, 64'd0);

    do_op(3'd1, 32'd5, 32'd3, cyc);
    chk("early_cycles", 64'(cyc), EARLY ? 64'd3 : 64'd33);
    chk("early_lo", {32'd0, lo}, 64'd15);
    chk("early_hi", {32'd0, hi}, 64'd0);

    start = 1'b1; op = 3'd0; a = 32'h0000_1234; b = 32'h0000_0010;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd0);
    chk("arst_hi", {32'd0, hi}, 64'd0);
    chk("arst_lo", {32'd0, lo}, 64'd0);
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", {63'd0, busy}, 64'd0);
    do_op(3'd1, 32'd6, 32'd7, cyc);
    chk("post_rst_lo", {32'd0, lo}, 64'd42);
    chk("post_rst_cycles", 64'(cyc), EARLY ? 64'd4 : 64'd33);

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
